load_unit: RTL
==============

Name: load_unit

Overview:
- Load execution unit directly downstream of the load issue queue.
- Consumes one issued load per transaction and adds the 32-bit immediate to the rs1 value from the PRF to form the address.
- Sends a single request to the data cache, then aligns and extends the returned word, and broadcasts the result on its CDB port.
- Back-pressures the issue queue through stall_fu while a transaction is in flight; a branch flush squashes the transaction without ever dropping a cache response.

Parameters:
PHYS_WIDTH, 6, physical register tag width
ROB_IDX_WIDTH, 5, ROB index width

Ports:
clk  in  1  clock
rst  in  1  reset
br_flush  in  1  squash all in-flight speculative work
iss_valid  in  1  load issued this cycle
iss_funct3  in  3  RV32I load funct3
iss_imm  in  32  sign-extended immediate
iss_rs1_data  in  32  base register value
iss_rd_paddr  in  PHYS_WIDTH  destination physical register
iss_rob_idx  in  ROB_IDX_WIDTH  ROB entry
stall_fu  out  1  high means issue is not accepted
dmem_addr  out  32  word-aligned address
dmem_rmask  out  4  byte read mask; nonzero for exactly one cycle per request
dmem_rdata  in  32  returned word
dmem_resp  in  1  response valid, exactly one per request
cdb_valid  out  1  result valid, one cycle
cdb_rd_paddr  out  PHYS_WIDTH  destination tag
cdb_rob_idx  out  ROB_IDX_WIDTH  ROB index
cdb_data  out  32  load result
cdb_exc  out  1  misaligned or illegal funct3

Behaviour:
- Reset: clk rising edge; rst is synchronous, active-high.
  - State goes to IDLE.
  - cdb_valid, cdb_exc, dmem_rmask and stall_fu are 0.
  - cdb_data, cdb_rd_paddr, cdb_rob_idx and dmem_addr are 0.
- States:
  - IDLE: accepting.
  - REQ: request driven.
  - WAIT: awaiting dmem_resp.
  - DONE: cdb_valid=1, accepting.
  - DRAIN: flushed, awaiting dmem_resp.
- Acceptance:
  - A load is accepted when iss_valid=1, stall_fu=0 and br_flush=0.
  - stall_fu = 1 in REQ, WAIT and DRAIN; 0 in IDLE and DONE.
- Address: addr = iss_rs1_data + iss_imm, modulo 2^32. addr, funct3, rd_paddr and rob_idx are latched at acceptance.
- Exception check at acceptance:
  - An exception is detected when:
    - funct3 is 3, 6 or 7, or
    - LH/LHU with addr[0]=1, or
    - LW with addr[1:0]!=0.
  - On an exception: go to DONE next cycle with cdb_exc=1 and cdb_data=0. No dmem request is made.
- Normal path for accepted load at cycle T:
  - T+1, state REQ:
    - dmem_addr = {addr[31:2],2'b00}.
    - dmem_rmask: LB/LBU 0001<<addr[1:0]; LH/LHU 0011<<addr[1:0]; LW 1111.
    - Go to WAIT, or directly to DONE if dmem_resp=1 in the same cycle.
  - WAIT: hold until dmem_resp=1 at cycle R.
  - R+1, state DONE:
    - cdb_valid=1 for exactly one cycle.
    - cdb_data = (dmem_rdata >> 8*addr[1:0]) truncated to the access size.
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- DONE: the next state is REQ or DONE if a new load is accepted that cycle (back-to-back, zero bubble), otherwise IDLE.
- br_flush:
  - In IDLE or DONE: any issue that cycle is ignored. Next state is IDLE, and cdb_valid=0 on the following cycle.
  - In REQ or WAIT: go to DRAIN, or to IDLE if dmem_resp arrives in the flush cycle. The response is discarded and no CDB broadcast is made.
  - In DRAIN: no effect. Stay until dmem_resp, discard it, then go to IDLE.
- dmem_resp outside REQ, WAIT and DRAIN is ignored. This is an assertion error in simulation.
- rst mid-transaction: go to IDLE immediately. The data cache is reset on the same rst, so no drain is needed.

Decomposition:
- Shared package (rv32i_types):
  - load funct3 enum (lb, lh, lw, lbu, lhu).
  - lu_state_t enum (IDLE, REQ, WAIT, DONE, DRAIN).
  - lu_cdb_t struct holding valid, rd_paddr, rob_idx, data and exc.
- Sub-module load_data_align: combinational; inputs funct3, addr[1:0], rdata; outputs rmask, aligned and extended data, and misalign flag. FSM and registers stay in load_unit.

Test Plan:
- LW with rs1=0x1000, imm=4, accepted at T → T+1: dmem_addr=0x1004, rmask=1111. dmem_resp at T+3 with rdata=0xDEADBEEF → T+4: cdb_valid=1, cdb_data=0xDEADBEEF, cdb_exc=0.
- Extension cases:
  - LB at 0x1003 with rdata=0x80FF0000 → rmask=1000, cdb_data=0xFFFFFF80.
  - LBU at the same address → cdb_data=0x00000080.
  - LH at 0x1002 with rdata=0x8001_1234 → rmask=1100, cdb_data=0xFFFF8001.
- LW at 0x1002 accepted at T → no rmask is ever driven. T+1: cdb_valid=1, cdb_exc=1, cdb_data=0; stall_fu=0.
- br_flush in WAIT, dmem_resp 3 cycles later → no cdb_valid. stall_fu stays 1 through the resp cycle and is 0 the cycle after; the next load is accepted then.
- Back-to-back LWs: the second iss_valid is held during the DONE cycle of the first → accepted. Its REQ is driven the cycle after DONE, with no gap.
- rst asserted in WAIT → next cycle: state IDLE, all outputs 0. A late dmem_resp is ignored and a new load is accepted normally.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared load unit types: funct3 codes, FSM states, CDB payload
package rv32i_types;

    localparam int LU_PHYS_W = 6;
    localparam int LU_ROB_W  = 5;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } lu_state_t;

    typedef struct packed {
        logic                 valid;
        logic [LU_PHYS_W-1:0] rd_paddr;
        logic [LU_ROB_W-1:0]  rob_idx;
        logic [31:0]          data;
        logic                 exc;
    } lu_cdb_t;

endpackage

// File: rtl/load_data_align.sv
// rtl/load_data_align.sv - byte mask, lane select/extension and misalign check for loads
module load_data_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  rmask_o,
    output logic [31:0] data_o,
    output logic        misalign_o
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    always_comb begin
        case (offset_i)
            2'd0:    b_sel = rdata_i[7:0];
            2'd1:    b_sel = rdata_i[15:8];
            2'd2:    b_sel = rdata_i[23:16];
            default: b_sel = rdata_i[31:24];
        endcase
        h_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // misalign_o also covers funct3 codes that are not loads
    always_comb begin
        rmask_o    = 4'b0000;
        data_o     = 32'h0;
        misalign_o = 1'b0;
        case (funct3_i)
            LD_LB: begin
                rmask_o = 4'b0001 << offset_i;
                data_o  = {{24{b_sel[7]}}, b_sel};
            end
            LD_LBU: begin
                rmask_o = 4'b0001 << offset_i;
                data_o  = {24'h0, b_sel};
            end
            LD_LH: begin
                rmask_o    = 4'b0011 << offset_i;
                data_o     = {{16{h_sel[15]}}, h_sel};
                misalign_o = offset_i[0];
            end
            LD_LHU: begin
                rmask_o    = 4'b0011 << offset_i;
                data_o     = {16'h0, h_sel};
                misalign_o = offset_i[0];
            end
            LD_LW: begin
                rmask_o    = 4'b1111;
                data_o     = rdata_i;
                misalign_o = |offset_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - single-outstanding load execution unit between issue queue, dcache and CDB
module load_unit
    import rv32i_types::*;
#(
    parameter int PHYS_WIDTH    = LU_PHYS_W,
    parameter int ROB_IDX_WIDTH = LU_ROB_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     br_flush,
    input  logic                     iss_valid,
    input  logic [2:0]               iss_funct3,
    input  logic [31:0]              iss_imm,
    input  logic [31:0]              iss_rs1_data,
    input  logic [PHYS_WIDTH-1:0]    iss_rd_paddr,
    input  logic [ROB_IDX_WIDTH-1:0] iss_rob_idx,
    output logic                     stall_fu,
    output logic [31:0]              dmem_addr,
    output logic [3:0]               dmem_rmask,
    input  logic [31:0]              dmem_rdata,
    input  logic                     dmem_resp,
    output logic                     cdb_valid,
    output logic [PHYS_WIDTH-1:0]    cdb_rd_paddr,
    output logic [ROB_IDX_WIDTH-1:0] cdb_rob_idx,
    output logic [31:0]              cdb_data,
    output logic                     cdb_exc
);

    lu_state_t                state_q, state_d;
    logic [31:0]              addr_q, addr_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [PHYS_WIDTH-1:0]    rd_q, rd_d;
    logic [ROB_IDX_WIDTH-1:0] rob_q, rob_d;
    lu_cdb_t                  cdb_q, cdb_d;

    logic [31:0] iss_addr;
    logic        in_flight;
    logic        accept;
    logic [2:0]  al_funct3;
    logic [1:0]  al_offset;
    logic [3:0]  al_rmask;
    logic [31:0] al_data;
    logic        al_misalign;

    assign iss_addr  = iss_rs1_data + iss_imm;
    assign in_flight = (state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN);
    assign stall_fu  = in_flight;
    assign accept    = iss_valid && !in_flight && !br_flush;

    // One aligner: it checks the incoming load while idle and formats the outstanding one otherwise
    assign al_funct3 = in_flight ? funct3_q : iss_funct3;
    assign al_offset = in_flight ? addr_q[1:0] : iss_addr[1:0];

    load_data_align u_align (
        .funct3_i   (al_funct3),
        .offset_i   (al_offset),
        .rdata_i    (dmem_rdata),
        .rmask_o    (al_rmask),
        .data_o     (al_data),
        .misalign_o (al_misalign)
    );

    assign dmem_addr    = {addr_q[31:2], 2'b00};
    assign dmem_rmask   = (state_q == REQ) ? al_rmask : 4'b0000;
    assign cdb_valid    = cdb_q.valid;
    assign cdb_rd_paddr = cdb_q.rd_paddr;
    assign cdb_rob_idx  = cdb_q.rob_idx;
    assign cdb_data     = cdb_q.data;
    assign cdb_exc      = cdb_q.exc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            rob_q    <= '0;
            cdb_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            rob_q    <= rob_d;
            cdb_q    <= cdb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        rob_d    = rob_q;
        cdb_d    = '0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d   = iss_addr;
                    funct3_d = iss_funct3;
                    rd_d     = iss_rd_paddr;
                    rob_d    = iss_rob_idx;
                    if (al_misalign) begin
                        state_d        = DONE;
                        cdb_d.valid    = 1'b1;
                        cdb_d.exc      = 1'b1;
                        cdb_d.rd_paddr = iss_rd_paddr;
                        cdb_d.rob_idx  = iss_rob_idx;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ, WAIT: begin
                if (br_flush) begin
                    state_d = dmem_resp ? IDLE : DRAIN;
                end else if (dmem_resp) begin
                    state_d        = DONE;
                    cdb_d.valid    = 1'b1;
                    cdb_d.rd_paddr = rd_q;
                    cdb_d.rob_idx  = rob_q;
                    cdb_d.data     = al_data;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                if (dmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A response with no request outstanding means the cache and this unit disagree
    always_ff @(posedge clk) begin
        if (!rst) assert (!(dmem_resp && !in_flight));
    end

endmodule
